// File: rtl/logic_gate_sweep_if.sv
// Bus between the sweep sequencer and the 3-input logic gate under test.
//   port_a/b/c : gate inputs, driven by the sequencer (a = vec[2], c = vec[0])
//   rslt_e..h  : gate outputs, sampled by the sequencer
// master = sequencer side, slave = gate side.
interface logic_gate_sweep_if;
    logic port_a;
    logic port_b;
    logic port_c;
    logic rslt_e;
    logic rslt_f;
    logic rslt_g;
    logic rslt_h;

    modport master (
        output port_a, port_b, port_c,
        input  rslt_e, rslt_f, rslt_g, rslt_h
    );

    modport slave (
        input  port_a, port_b, port_c,
        output rslt_e, rslt_f, rslt_g, rslt_h
    );
endinterface

// File: rtl/logic_gate_sweep.sv
// Exhaustive sweep sequencer for a 3-input logic gate.
// Drives all 8 input vectors in order, holds each for DWELL_CYC settle cycles plus one
// capture cycle, records the gate outputs into per-output truth tables and compares a
// completed pass against the EXP_* tables.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   start, stop        : begin a pass (ignored while busy) / abort pass or leave loop mode
//   loop_en            : restart at vector 0 after each completed pass
//   gate               : gate bus (port_a/b/c out, rslt_e..h in)
//   busy               : pass in progress
//   sample_vld/idx/dat : 1-cycle pulse per captured vector, its index and {e,f,g,h}
//   done               : 1-cycle pulse at the end of a full pass
//   tt_e..tt_h         : captured truth tables, bit i = result for vector i
//   tt_valid           : tables hold one complete pass
//   mismatch           : last completed pass differed from EXP_*; held until next start
module logic_gate_sweep #(
    parameter int unsigned DWELL_CYC = 2,
    parameter logic [7:0]  EXP_E     = 8'h00,
    parameter logic [7:0]  EXP_F     = 8'h00,
    parameter logic [7:0]  EXP_G     = 8'h00,
    parameter logic [7:0]  EXP_H     = 8'h00
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    logic_gate_sweep_if.master        gate,
    output logic                      busy,
    output logic                      sample_vld,
    output logic [2:0]                sample_idx,
    output logic [3:0]                sample_dat,
    output logic                      done,
    output logic [7:0]                tt_e,
    output logic [7:0]                tt_f,
    output logic [7:0]                tt_g,
    output logic [7:0]                tt_h,
    output logic                      tt_valid,
    output logic                      mismatch
);

    localparam int unsigned    CntW    = $clog2(DWELL_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYC - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      vec_q, vec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tt_e_q, tt_e_d, tt_f_q, tt_f_d, tt_g_q, tt_g_d, tt_h_q, tt_h_d;
    logic            tt_valid_q, tt_valid_d;
    logic            mismatch_q, mismatch_d;
    logic            capture;
    logic [2:0]      ports_q;
    logic            busy_q, sample_vld_q, done_q;
    logic [2:0]      sample_idx_q;
    logic [3:0]      sample_dat_q;
    logic [3:0]      rslt;

    assign rslt = {gate.rslt_e, gate.rslt_f, gate.rslt_g, gate.rslt_h};

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        tt_e_d     = tt_e_q;
        tt_f_d     = tt_f_q;
        tt_g_d     = tt_g_q;
        tt_h_d     = tt_h_q;
        tt_valid_d = tt_valid_q;
        mismatch_d = mismatch_q;
        capture    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d    = StSettle;
                    vec_d      = 3'd0;
                    cnt_d      = '0;
                    tt_valid_d = 1'b0;
                    mismatch_d = 1'b0;
                end
            end
            StSettle: begin
                if (stop) begin
                    state_d = StIdle;
                    vec_d   = 3'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapture: begin
                // stop wins over the capture: the aborted vector is not recorded
                if (stop) begin
                    state_d = StIdle;
                    vec_d   = 3'd0;
                end else begin
                    capture         = 1'b1;
                    tt_e_d[vec_q]   = rslt[3];
                    tt_f_d[vec_q]   = rslt[2];
                    tt_g_d[vec_q]   = rslt[1];
                    tt_h_d[vec_q]   = rslt[0];
                    if (vec_q == 3'd7) begin
                        state_d    = StDone;
                        tt_valid_d = 1'b1;
                        // compare against the tables including this last capture
                        mismatch_d = (tt_e_d != EXP_E) || (tt_f_d != EXP_F) ||
                                     (tt_g_d != EXP_G) || (tt_h_d != EXP_H);
                    end else begin
                        state_d = StSettle;
                        vec_d   = vec_q + 3'd1;
                        cnt_d   = '0;
                    end
                end
            end
            StDone: begin
                if (loop_en && !stop) begin
                    state_d    = StSettle;
                    vec_d      = 3'd0;
                    cnt_d      = '0;
                    tt_valid_d = 1'b0;
                end else begin
                    state_d = StIdle;
                    vec_d   = 3'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            vec_q        <= 3'd0;
            cnt_q        <= '0;
            tt_e_q       <= 8'h00;
            tt_f_q       <= 8'h00;
            tt_g_q       <= 8'h00;
            tt_h_q       <= 8'h00;
            tt_valid_q   <= 1'b0;
            mismatch_q   <= 1'b0;
            ports_q      <= 3'd0;
            busy_q       <= 1'b0;
            sample_vld_q <= 1'b0;
            sample_idx_q <= 3'd0;
            sample_dat_q <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            tt_e_q       <= tt_e_d;
            tt_f_q       <= tt_f_d;
            tt_g_q       <= tt_g_d;
            tt_h_q       <= tt_h_d;
            tt_valid_q   <= tt_valid_d;
            mismatch_q   <= mismatch_d;
            ports_q      <= (state_d != StIdle) ? vec_d : 3'd0;
            busy_q       <= (state_d != StIdle);
            sample_vld_q <= capture;
            done_q       <= (state_d == StDone);
            if (capture) begin
                sample_idx_q <= vec_q;
                sample_dat_q <= rslt;
            end
        end
    end

    assign gate.port_a = ports_q[2];
    assign gate.port_b = ports_q[1];
    assign gate.port_c = ports_q[0];
    assign busy        = busy_q;
    assign sample_vld  = sample_vld_q;
    assign sample_idx  = sample_idx_q;
    assign sample_dat  = sample_dat_q;
    assign done        = done_q;
    assign tt_e        = tt_e_q;
    assign tt_f        = tt_f_q;
    assign tt_g        = tt_g_q;
    assign tt_h        = tt_h_q;
    assign tt_valid    = tt_valid_q;
    assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Self-checking bench for logic_gate_sweep (DWELL_CYC=2, EXP_E=8'h80).
// Cycle n = the clock period following the edge that sampled start (edge n); outputs are
// checked on the falling edge. A behavioural gate model answers the sequencer's vectors;
// expected captures are queued when a pass is launched and popped as sample_vld pulses.
module tb_logic_gate_sweep;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic       loop_en   = 1'b0;
    logic       busy, sample_vld, done, tt_valid, mismatch;
    logic [2:0] sample_idx;
    logic [3:0] sample_dat;
    logic [7:0] tt_e, tt_f, tt_g, tt_h;
    logic [2:0] ports;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    logic [6:0] sb_q[$];  // {idx, {e,f,g,h}}

    logic_gate_sweep_if gate ();

    always #5 sys_clk = ~sys_clk;

    // mode 0: e=a&b&c; mode 1: e=a|b; mode 2: e=a&b&c, f=a^b^c, g=~c, h=b
    function automatic logic [3:0] model(input int m, input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        case (m)
            1:       return {a | b, 3'b000};
            2:       return {a & b & c, a ^ b ^ c, ~c, b};
            default: return {a & b & c, 3'b000};
        endcase
    endfunction

    // col 0 = e .. 3 = h
    function automatic logic [7:0] table_of(input int m, input int col);
        logic [7:0] t;
        logic [3:0] r;
        for (int i = 0; i < 8; i++) begin
            r    = model(m, 3'(i));
            t[i] = r[3 - col];
        end
        return t;
    endfunction

    assign ports = {gate.port_a, gate.port_b, gate.port_c};
    assign {gate.rslt_e, gate.rslt_f, gate.rslt_g, gate.rslt_h} = model(mode, ports);

    logic_gate_sweep #(
        .DWELL_CYC (2),
        .EXP_E     (8'h80),
        .EXP_F     (8'h00),
        .EXP_G     (8'h00),
        .EXP_H     (8'h00)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .gate       (gate),
        .busy       (busy),
        .sample_vld (sample_vld),
        .sample_idx (sample_idx),
        .sample_dat (sample_dat),
        .done       (done),
        .tt_e       (tt_e),
        .tt_f       (tt_f),
        .tt_g       (tt_g),
        .tt_h       (tt_h),
        .tt_valid   (tt_valid),
        .mismatch   (mismatch)
    );

    // scoreboard: every capture pulse must match the next queued expectation
    always @(negedge sys_clk) begin : sb_mon
        logic [6:0] exp_s;
        if (sample_vld === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected: got idx=%0d dat=%h, required no capture",
                         sample_idx, sample_dat);
            end else begin
                exp_s = sb_q.pop_front();
                if ({sample_idx, sample_dat} !== exp_s) begin
                    errors++;
                    $display("FAIL sample: got idx=%0d dat=%h, required idx=%0d dat=%h",
                             sample_idx, sample_dat, exp_s[6:4], exp_s[3:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push_pass(input int m, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({3'(i), model(m, 3'(i))});
    endtask

    // returns on the falling edge of cycle 0
    task automatic start_pass();
        @(negedge sys_clk);
        start = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left: got %0d pending captures, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [38:0] obs;
        start     = 1'b1;
        sys_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            obs = {busy, ports, done, tt_valid, mismatch, sample_vld, tt_e, tt_f, tt_g, tt_h};
            checks++;
            if (obs !== 39'd0) begin
                errors++;
                $display("FAIL reset_%0d: got %h, required 0", i, obs);
            end
        end
        start     = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_timing();
        logic [6:0] obs, exp_v;
        int p;
        mode = 0;
        push_pass(0, 8);
        start_pass();
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) @(negedge sys_clk);
            p     = (n > 24) ? 0 : ((n / 3 > 7) ? 7 : n / 3);
            exp_v = {3'(p), n <= 24, n == 24, (n >= 3) && (n % 3 == 0) && (n <= 24), n >= 24};
            obs   = {ports, busy, done, sample_vld, tt_valid};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL timing_c%0d {ports,busy,done,vld,ttv}: got %b, required %b",
                         n, obs, exp_v);
            end
            if (n == 24) begin
                checks++;
                if ({tt_e, tt_f, tt_g, tt_h, mismatch} !== {8'h80, 24'h0, 1'b0}) begin
                    errors++;
                    $display("FAIL timing_tables: got e=%h f=%h g=%h h=%h mm=%b, required 80 0 0 0 0",
                             tt_e, tt_f, tt_g, tt_h, mismatch);
                end
            end
        end
        check_sb_empty("timing");
    endtask

    task automatic test_check();
        int cyc;
        mode = 1;
        push_pass(1, 8);
        start_pass();
        wait_done(40, cyc);
        checks++;
        if (cyc != 24) begin
            errors++;
            $display("FAIL check_latency: got done at cycle %0d, required 24", cyc);
        end
        checks++;
        if ({tt_e, tt_valid, mismatch} !== {8'hFC, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL check_mismatch: got tt_e=%h ttv=%b mm=%b, required FC 1 1",
                     tt_e, tt_valid, mismatch);
        end
        @(negedge sys_clk);
        checks++;
        if ({busy, tt_valid, mismatch} !== 3'b011) begin
            errors++;
            $display("FAIL check_hold: got busy/ttv/mm=%b, required 011", {busy, tt_valid, mismatch});
        end
        check_sb_empty("check");
    endtask

    task automatic test_tables();
        int cyc;
        mode = 2;
        push_pass(2, 8);
        start_pass();
        checks++;
        if ({tt_valid, mismatch} !== 2'b00) begin
            errors++;
            $display("FAIL tables_clear: got ttv/mm=%b, required 00", {tt_valid, mismatch});
        end
        wait_done(40, cyc);
        checks++;
        if (cyc != 24) begin
            errors++;
            $display("FAIL tables_latency: got done at cycle %0d, required 24", cyc);
        end
        checks++;
        if ({tt_e, tt_f, tt_g, tt_h, mismatch} !==
            {table_of(2, 0), table_of(2, 1), table_of(2, 2), table_of(2, 3), 1'b1}) begin
            errors++;
            $display("FAIL tables: got e=%h f=%h g=%h h=%h mm=%b, required %h %h %h %h 1",
                     tt_e, tt_f, tt_g, tt_h, mismatch, table_of(2, 0), table_of(2, 1),
                     table_of(2, 2), table_of(2, 3));
        end
        @(negedge sys_clk);
        check_sb_empty("tables");
    endtask

    // runs right after a mode-2 pass so kept bits are distinguishable from new ones
    task automatic test_abort();
        logic [31:0] exp_t;
        int seen_done;
        mode = 0;
        push_pass(0, 3);
        start_pass();
        for (int n = 1; n <= 10; n++) @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        checks++;
        if ({ports, busy, done, tt_valid} !== 6'd0) begin
            errors++;
            $display("FAIL abort_idle: got ports=%b busy=%b done=%b ttv=%b, required 0",
                     ports, busy, done, tt_valid);
        end
        for (int c = 0; c < 4; c++) begin
            exp_t[31 - 8*c -: 8] = (table_of(2, c) & 8'hF8) | (table_of(0, c) & 8'h07);
        end
        checks++;
        if ({tt_e, tt_f, tt_g, tt_h} !== exp_t) begin
            errors++;
            $display("FAIL abort_partial: got %h, required %h", {tt_e, tt_f, tt_g, tt_h}, exp_t);
        end
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d cycles with done/busy, required 0", seen_done);
        end
        check_sb_empty("abort");
    endtask

    // DONE takes one cycle, so looped passes end 25 cycles apart
    task automatic test_loop();
        logic [4:0] obs, exp_v;
        int m, p;
        mode    = 0;
        loop_en = 1'b1;
        push_pass(0, 8);
        push_pass(0, 8);
        start_pass();
        for (int n = 0; n <= 51; n++) begin
            if (n > 0) @(negedge sys_clk);
            m     = (n <= 24) ? n : ((n <= 49) ? n - 25 : 0);
            p     = (n >= 51) ? 0 : ((m / 3 > 7) ? 7 : m / 3);
            exp_v = {3'(p), n <= 50, (n == 24) || (n == 49)};
            obs   = {ports, busy, done};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL loop_c%0d {ports,busy,done}: got %b, required %b", n, obs, exp_v);
            end
            if (n == 50) stop = 1'b1;
        end
        stop    = 1'b0;
        loop_en = 1'b0;
        check_sb_empty("loop");
    endtask

    task automatic test_robust();
        logic [3:0] obs, exp_v;
        logic [39:0] rst_obs;
        int active;
        mode = 0;
        push_pass(0, 5);
        start_pass();
        for (int n = 1; n <= 16; n++) begin
            @(negedge sys_clk);
            if (n == 13) start = 1'b0;
            exp_v = {3'((n <= 15) ? n / 3 : 0), n <= 15};
            obs   = {ports, busy};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL robust_c%0d {ports,busy}: got %b, required %b", n, obs, exp_v);
            end
            if (n == 12) start = 1'b1;
            if (n == 15) sys_rst_n = 1'b0;
        end
        rst_obs = {busy, ports, done, tt_valid, mismatch, sample_vld, tt_e, tt_f, tt_g, tt_h, 1'b0};
        checks++;
        if (rst_obs !== 40'd0) begin
            errors++;
            $display("FAIL robust_reset: got %h, required 0", rst_obs);
        end
        sys_rst_n = 1'b1;
        active    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (done !== 1'b0 || busy !== 1'b0) active++;
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL robust_quiet: got %0d cycles with done/busy, required 0", active);
        end
        check_sb_empty("robust");
    endtask

    initial begin
        test_reset();
        test_timing();
        test_check();
        test_tables();
        test_abort();
        test_loop();
        test_robust();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
